rgb_to_bayer_tx: RTL and testbench

Re-mosaics a parallel RGB video stream (vsync/hsync/de + 3×12-bit colour) into a raw 12-bit Bayer sensor-style stream (frame_valid/line_valid/pixdata). It is the reverse of the camera image pipe. It feeds recorded or generated RGB frames back into the raw-input path as a sensor emulator, for loopback test and for pattern injection ahead of the FIFO/debayer chain. It also checks frame geometry and flags malformed frames.

---
 rtl/rgb_to_bayer_pkg.sv | 22 ++
 rtl/rgb_to_bayer_tx_bayer_site_sel.sv | 26 ++
 rtl/rgb_to_bayer_tx.sv | 185 ++++++++++++++++++
 tb/tb_rgb_to_bayer_tx.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_to_bayer_pkg.sv
// Shared types for the RGB-to-Bayer sensor emulator.
// CFA phase codes, FSM state enum and channel-select enum.
package rgb_to_bayer_pkg;

  localparam logic [1:0] PH_RGGB = 2'd0;
  localparam logic [1:0] PH_GRBG = 2'd1;
  localparam logic [1:0] PH_GBRG = 2'd2;
  localparam logic [1:0] PH_BGGR = 2'd3;

  typedef enum logic [1:0] {
    SYNC_WAIT,
    IDLE,
    ACTIVE
  } state_t;

  typedef enum logic [1:0] {
    SEL_R,
    SEL_G,
    SEL_B
  } sel_t;

endpackage

// File: rtl/rgb_to_bayer_tx_bayer_site_sel.sv
// Bayer CFA site decoder: (x[0], y[0], phase) -> colour channel.
// Ports: x0, y0, phase[1:0] in; sel[1:0] out (sel_t code).
module bayer_site_sel
  import rgb_to_bayer_pkg::*;
(
  input  logic       x0,
  input  logic       y0,
  input  logic [1:0] phase,
  output logic [1:0] sel
);

  logic r;
  logic c;

  always_comb begin
    r   = y0 ^ phase[1];
    c   = x0 ^ phase[0];
    sel = SEL_G;
    unique case (1'b1)
      (!r && !c): sel = SEL_R;
      (r && c):   sel = SEL_B;
      default:    sel = SEL_G;
    endcase
  end

endmodule

// File: rtl/rgb_to_bayer_tx.sv
// RGB (vsync/hsync/de) to raw Bayer (frame/line valid) re-mosaic.
// Ports: clk, reset_n, sync/de/rgb in; fv/lv/pixdata, errs out.
module rgb_to_bayer_tx
  import rgb_to_bayer_pkg::*;
#(
  parameter int         H_ACTIVE    = 1920,
  parameter int         V_ACTIVE    = 1080,
  parameter logic [1:0] BAYER_PHASE = PH_RGGB,
  parameter logic       VS_POL      = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        de_in,
  input  logic [35:0] rgb_data,
  output logic        frame_valid,
  output logic        line_valid,
  output logic [11:0] pixdata,
  output logic        line_err,
  output logic        frame_err
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);

  localparam logic [XW-1:0] X_H    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_MAX  = {XW{1'b1}};
  localparam logic [YW-1:0] Y_V    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX  = {YW{1'b1}};

  logic unused;
  assign unused = hsync_in;

  state_t state;
  state_t state_n;

  logic          vs_prev;
  logic          de_prev;
  logic          vs_act;
  logic          vs_lead;
  logic          de_rise;
  logic          de_fall;
  logic [XW-1:0] x;
  logic [XW-1:0] x_n;
  logic [XW-1:0] idx;
  logic [YW-1:0] y;
  logic [YW-1:0] y_n;
  logic [YW-1:0] y_eff;

  logic          p_valid_n;
  logic          lerr_n;
  logic          ferr_n;

  logic          s1_valid;
  logic          s1_fv;
  logic          s1_x0;
  logic          s1_y0;
  logic          s1_lerr;
  logic          s1_ferr;
  logic [35:0]   s1_rgb;

  logic [1:0]    sel;
  logic [11:0]   chan;

  always_comb begin
    vs_act  = (vsync_in == VS_POL);
    vs_lead = vs_act && !vs_prev;
    de_rise = de_in && !de_prev;
    de_fall = !de_in && de_prev;
    // vsync wins: counters restart before any
    // same-cycle de edge is applied
    y_eff   = vs_lead ? '0 : y;
    idx     = (de_rise || vs_lead) ? '0 : x;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      SYNC_WAIT: begin
        if (vs_lead)
          state_n = de_rise ? ACTIVE : IDLE;
      end
      IDLE: begin
        if (de_rise && y_eff < Y_V)
          state_n = ACTIVE;
      end
      ACTIVE: begin
        if (vs_lead)
          state_n = de_rise ? ACTIVE : IDLE;
        else if (de_fall && y == Y_LAST)
          state_n = IDLE;
      end
      default: state_n = SYNC_WAIT;
    endcase
  end

  always_comb begin
    x_n = x;
    y_n = y;
    if (vs_lead) begin
      x_n = '0;
      y_n = '0;
    end
    if (de_in)
      x_n = (idx == X_MAX) ? idx : idx + 1'b1;
    if (de_fall && !vs_lead && y != Y_MAX)
      y_n = y + 1'b1;
  end

  always_comb begin
    p_valid_n = de_in && (state_n == ACTIVE)
             && (idx < X_H) && (y_eff < Y_V);
    lerr_n    = de_fall && (state == ACTIVE)
             && (x != X_H);
    ferr_n    = vs_lead && (state != SYNC_WAIT)
             && (y != Y_V);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SYNC_WAIT;
      // a vsync already active at release is not
      // a leading edge
      vs_prev  <= 1'b1;
      de_prev  <= 1'b0;
      x        <= '0;
      y        <= '0;
      s1_valid <= 1'b0;
      s1_fv    <= 1'b0;
      s1_x0    <= 1'b0;
      s1_y0    <= 1'b0;
      s1_lerr  <= 1'b0;
      s1_ferr  <= 1'b0;
      s1_rgb   <= '0;
    end else begin
      state    <= state_n;
      vs_prev  <= vs_act;
      de_prev  <= de_in;
      x        <= x_n;
      y        <= y_n;
      s1_valid <= p_valid_n;
      s1_fv    <= (state_n == ACTIVE);
      s1_x0    <= idx[0];
      s1_y0    <= y_eff[0];
      s1_lerr  <= lerr_n;
      s1_ferr  <= ferr_n;
      s1_rgb   <= rgb_data;
    end
  end

  bayer_site_sel u_site (
    .x0    (s1_x0),
    .y0    (s1_y0),
    .phase (BAYER_PHASE),
    .sel   (sel)
  );

  always_comb begin
    chan = s1_rgb[23:12];
    unique case (1'b1)
      (sel == SEL_R): chan = s1_rgb[35:24];
      (sel == SEL_B): chan = s1_rgb[11:0];
      default:        chan = s1_rgb[23:12];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_valid <= 1'b0;
      line_valid  <= 1'b0;
      pixdata     <= '0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= s1_fv;
      line_valid  <= s1_valid;
      pixdata     <= s1_valid ? chan : 12'h000;
      line_err    <= s1_lerr;
      frame_err   <= s1_ferr;
    end
  end

endmodule

// File: tb/tb_rgb_to_bayer_tx.sv
// Bench for rgb_to_bayer_tx: phase 0 and phase 3 instances.
// Random frames vs. a pixel-list model; directed edge cases.
module tb_rgb_to_bayer_tx;

  localparam int H = 4;
  localparam int V = 2;
  localparam int N = 512;

  logic        clk;
  logic        reset_n;
  logic        vsync_in;
  logic        hsync_in;
  logic        de_in;
  logic [35:0] rgb_data;

  logic        fv [2];
  logic        lv [2];
  logic [11:0] pix [2];
  logic        le [2];
  logic        fe [2];

  rgb_to_bayer_tx #(
    .H_ACTIVE(H), .V_ACTIVE(V),
    .BAYER_PHASE(2'd0), .VS_POL(1'b1)
  ) dut0 (
    .clk(clk), .reset_n(reset_n),
    .vsync_in(vsync_in), .hsync_in(hsync_in),
    .de_in(de_in), .rgb_data(rgb_data),
    .frame_valid(fv[0]), .line_valid(lv[0]),
    .pixdata(pix[0]), .line_err(le[0]),
    .frame_err(fe[0])
  );

  rgb_to_bayer_tx #(
    .H_ACTIVE(H), .V_ACTIVE(V),
    .BAYER_PHASE(2'd3), .VS_POL(1'b1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n),
    .vsync_in(vsync_in), .hsync_in(hsync_in),
    .de_in(de_in), .rgb_data(rgb_data),
    .frame_valid(fv[1]), .line_valid(lv[1]),
    .pixdata(pix[1]), .line_err(le[1]),
    .frame_err(fe[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor state (written only by the monitor)
  logic [11:0] obs [2][N];
  int   npix [2];
  int   nlerr [2];
  int   nferr [2];
  int   nviol [2];
  int   fv_rise [2];
  int   fv_fall [2];
  int   last_lv [2];
  int   lerr_at [2];
  int   ferr_at [2];
  logic ferr_fv [2];
  logic fv_q [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      npix[d] = 0; nlerr[d] = 0; nferr[d] = 0;
      nviol[d] = 0; fv_q[d] = 1'b0;
      fv_rise[d] = 0; fv_fall[d] = 0;
      last_lv[d] = 0; lerr_at[d] = 0;
      ferr_at[d] = 0; ferr_fv[d] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (lv[d]) begin
          obs[d][npix[d] % N] = pix[d];
          npix[d]++;
          last_lv[d] = cyc;
        end else if (pix[d] !== 12'h000) begin
          nviol[d]++;
        end
        if (lv[d] && !fv[d]) nviol[d]++;
        if (fv[d] && !fv_q[d]) begin
          fv_rise[d] = cyc;
          if (!lv[d]) nviol[d]++;
        end
        if (!fv[d] && fv_q[d]) fv_fall[d] = cyc;
        if (le[d]) begin
          nlerr[d]++;
          lerr_at[d] = cyc;
        end
        if (fe[d]) begin
          nferr[d]++;
          ferr_at[d] = cyc;
          ferr_fv[d] = fv[d];
        end
        fv_q[d] = fv[d];
      end
    end
  end

  // reference model and bench state (main process only)
  int          total;
  int          bad;
  logic [11:0] expv [2][N];
  int          nexp [2];
  int          chkd [2];
  int          exp_lerr;
  int          exp_ferr;
  int          lines;
  bit          armed;
  bit          emit;
  int          vs_cyc;
  int          fall_cyc;
  int          first_de;
  int          ph [2];

  function automatic logic [11:0] pick(
    input int p, input int ln, input int col,
    input logic [35:0] rgb
  );
    int r;
    int c;
    r = (ln % 2) ^ (p / 2);
    c = (col % 2) ^ (p % 2);
    if (r == 0 && c == 0) return rgb[35:24];
    if (r == 1 && c == 1) return rgb[11:0];
    return rgb[23:12];
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] expd
  );
    total++;
    assert (got === expd) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h",
             tag, got, expd);
    end
  endtask

  task automatic blank(input int n);
    repeat (n) begin
      @(negedge clk);
      de_in    = 1'b0;
      hsync_in = 1'b0;
      rgb_data = {4'($urandom()), $urandom()};
    end
  endtask

  task automatic vsync_edge();
    @(negedge clk);
    vsync_in = 1'b1;
    de_in    = 1'b0;
    vs_cyc   = cyc;
    if (armed && lines != V) exp_ferr++;
    armed = 1'b1;
    emit  = 1'b1;
    lines = 0;
    blank(2);
    @(negedge clk);
    vsync_in = 1'b0;
    blank(2);
  endtask

  task automatic send_line(
    input int len, input bit fixed
  );
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      de_in    = 1'b1;
      hsync_in = (i == 0);
      rgb_data = fixed ? 36'h111222333
                       : {4'($urandom()), $urandom()};
      if (i == 0 && lines == 0) first_de = cyc;
      if (emit && lines < V && i < H) begin
        for (int d = 0; d < 2; d++) begin
          expv[d][nexp[d] % N] =
            pick(ph[d], lines, i, rgb_data);
          nexp[d]++;
        end
      end
    end
    @(negedge clk);
    de_in    = 1'b0;
    fall_cyc = cyc;
    if (emit && lines < V && len != H) exp_lerr++;
    lines++;
    blank(1 + int'($urandom() % 3));
  endtask

  task automatic check_step(input string tag);
    int lim;
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_cnt"}, npix[d], nexp[d]);
      lim = (npix[d] < nexp[d]) ? npix[d] : nexp[d];
      for (int k = chkd[d]; k < lim; k++)
        chk({tag, "_pix"}, 32'(obs[d][k % N]),
            32'(expv[d][k % N]));
      chkd[d] = lim;
      chk({tag, "_lerr"}, nlerr[d], exp_lerr);
      chk({tag, "_ferr"}, nferr[d], exp_ferr);
      chk({tag, "_viol"}, nviol[d], 0);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_fv"}, 32'(fv[d]), 0);
      chk({tag, "_lv"}, 32'(lv[d]), 0);
      chk({tag, "_pix"}, 32'(pix[d]), 0);
      chk({tag, "_le"}, 32'(le[d]), 0);
      chk({tag, "_fe"}, 32'(fe[d]), 0);
    end
  endtask

  initial begin
    int nl;
    total = 0; bad = 0;
    exp_lerr = 0; exp_ferr = 0;
    lines = 0; armed = 1'b0; emit = 1'b0;
    vs_cyc = 0; fall_cyc = 0; first_de = 0;
    ph[0] = 0; ph[1] = 3;
    for (int d = 0; d < 2; d++) begin
      nexp[d] = 0; chkd[d] = 0;
    end
    reset_n  = 1'b0;
    vsync_in = 1'b0;
    hsync_in = 1'b0;
    de_in    = 1'b0;
    rgb_data = '0;
    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    reset_n = 1'b1;
    blank(2);

    // de before the first vsync is dropped
    send_line(4, 1'b0);
    send_line(4, 1'b0);
    check_step("pre_vs");
    vsync_edge();
    check_step("first_vs");

    // directed 4x2 frame, constant colours
    send_line(4, 1'b1);
    send_line(4, 1'b1);
    check_step("fixed");
    chk("fixed_npix", npix[0], 8);
    chk("lat0", fv_rise[0] - first_de, 2);
    chk("lat1", fv_rise[1] - first_de, 2);
    chk("fv_tail0", fv_fall[0] - last_lv[0], 1);
    chk("fv_tail1", fv_fall[1] - last_lv[1], 1);
    vsync_edge();
    check_step("fixed_end");

    // random full frames
    repeat (3) begin
      send_line(4, 1'b0);
      send_line(4, 1'b0);
      vsync_edge();
      check_step("rnd_full");
    end

    // random geometry
    repeat (4) begin
      nl = 1 + int'($urandom() % 3);
      for (int l = 0; l < nl; l++)
        send_line(1 + int'($urandom() % 6), 1'b0);
      vsync_edge();
      check_step("rnd_geom");
    end

    // short line then long line
    send_line(3, 1'b0);
    send_line(6, 1'b0);
    chk("lerr_lat", lerr_at[0] - fall_cyc, 2);
    check_step("short_long");
    vsync_edge();
    check_step("short_long_end");

    // early vsync after one line
    send_line(4, 1'b0);
    vsync_edge();
    chk("ferr_lat", ferr_at[0] - vs_cyc, 2);
    chk("ferr_fv", 32'(ferr_fv[0]), 0);
    chk("fv_early", fv_fall[0] - vs_cyc, 2);
    check_step("early_vs");

    // reset in the middle of a line
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      de_in    = 1'b1;
      rgb_data = {4'($urandom()), $urandom()};
      for (int d = 0; d < 2; d++) begin
        expv[d][nexp[d] % N] =
          pick(ph[d], 0, i, rgb_data);
        nexp[d]++;
      end
    end
    @(negedge clk);
    chk("lv_pre_rst", 32'(lv[0]), 1);
    reset_n = 1'b0;
    #1;
    chk_outs_zero("async_rst");
    for (int d = 0; d < 2; d++) nexp[d] = npix[d];
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    armed = 1'b0;
    emit  = 1'b0;
    lines = 0;
    repeat (2) begin
      @(negedge clk);
      rgb_data = {4'($urandom()), $urandom()};
    end
    blank(2);
    send_line(4, 1'b0);
    check_step("post_rst");
    vsync_edge();
    check_step("post_rst_vs");
    send_line(4, 1'b0);
    send_line(4, 1'b0);
    vsync_edge();
    check_step("post_rst_frame");

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
